// File: rtl/stump_cc_writeback_if.sv
// Record channels around the Stump execute-to-writeback stage: the ALU record coming in,
// the registered writeback/memory/branch record going out, and the visible CC register.
interface stump_cc_writeback_if #(
  parameter int unsigned DW = 16
) ();

  // Upstream ALU record
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_result;
  logic [3:0]    alu_flags;
  logic [2:0]    alu_func;
  logic          set_cc;
  logic [2:0]    dest;
  logic [3:0]    cond;

  // Downstream registered record
  logic          out_valid;
  logic          out_ready;
  logic          wb_en;
  logic [2:0]    wb_dest;
  logic [DW-1:0] wb_data;
  logic          mem_req;
  logic [DW-1:0] mem_addr;
  logic          br_taken;
  logic [DW-1:0] br_target;
  logic [3:0]    cc;

  // The stage itself
  modport slave (
    input  in_valid, alu_result, alu_flags, alu_func, set_cc, dest, cond, out_ready,
    output in_ready, out_valid, wb_en, wb_dest, wb_data, mem_req, mem_addr, br_taken,
    output br_target, cc
  );

  // Whatever drives the ALU record and consumes the writeback record
  modport master (
    output in_valid, alu_result, alu_flags, alu_func, set_cc, dest, cond, out_ready,
    input  in_ready, out_valid, wb_en, wb_dest, wb_data, mem_req, mem_addr, br_taken,
    input  br_target, cc
  );

endinterface

// File: rtl/stump_cc_writeback.sv
// Stump execute-to-writeback stage: registers the ALU record, owns the {N,Z,V,C} condition
// code register, resolves branch conditions and presents the result over valid/ready.
module stump_cc_writeback #(
  parameter int unsigned DW       = 16,
  parameter logic [3:0]  RESET_CC = 4'b0000
) (
  input logic                  clk,
  input logic                  rst_n,
  stump_cc_writeback_if.slave  bus
);

  localparam logic [2:0] FuncMem = 3'b110;
  localparam logic [2:0] FuncBr  = 3'b111;

  logic          out_valid_q, out_valid_d;
  logic          wb_en_q, wb_en_d;
  logic [2:0]    wb_dest_q, wb_dest_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          mem_req_q, mem_req_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic          br_taken_q, br_taken_d;
  logic [DW-1:0] br_target_q, br_target_d;
  logic [3:0]    cc_q, cc_d;

  logic in_ready;
  logic accept;
  logic transfer;
  logic is_data_proc;

  // Branch condition against {N,Z,V,C}; C is borrow-style. Unknown codes fall to not-taken.
  function automatic logic cond_met(input logic [3:0] code, input logic [3:0] flags);
    logic n, z, v, c;
    {n, z, v, c} = flags;
    case (code)
      4'd0:    cond_met = 1'b1;
      4'd1:    cond_met = 1'b0;
      4'd2:    cond_met = !c && !z;
      4'd3:    cond_met = c || z;
      4'd4:    cond_met = !c;
      4'd5:    cond_met = c;
      4'd6:    cond_met = !z;
      4'd7:    cond_met = z;
      4'd8:    cond_met = !v;
      4'd9:    cond_met = v;
      4'd10:   cond_met = !n;
      4'd11:   cond_met = n;
      4'd12:   cond_met = (n == v);
      4'd13:   cond_met = (n != v);
      4'd14:   cond_met = !z && (n == v);
      4'd15:   cond_met = z || (n != v);
      default: cond_met = 1'b0;
    endcase
  endfunction

  // Handshake: a held record can be replaced in the same cycle it is consumed
  always_comb begin
    in_ready     = !out_valid_q || bus.out_ready;
    accept       = bus.in_valid && in_ready;
    transfer     = out_valid_q && bus.out_ready;
    is_data_proc = (bus.alu_func != FuncMem) && (bus.alu_func != FuncBr);
  end

  // Next-state: decode an accepted record, otherwise hold (or drop valid after transfer)
  always_comb begin
    out_valid_d = out_valid_q;
    wb_en_d     = wb_en_q;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    cc_d        = cc_q;

    if (accept) begin
      out_valid_d = 1'b1;
      wb_en_d     = 1'b0;
      mem_req_d   = 1'b0;
      br_taken_d  = 1'b0;
      if (bus.alu_func == FuncMem) begin
        mem_req_d  = 1'b1;
        mem_addr_d = bus.alu_result;
      end else if (bus.alu_func == FuncBr) begin
        // cc_q is the pre-update value; branches never write CC so no hazard exists
        br_taken_d  = cond_met(bus.cond, cc_q);
        br_target_d = bus.alu_result;
      end else begin
        wb_en_d   = 1'b1;
        wb_dest_d = bus.dest;
        wb_data_d = bus.alu_result;
      end
      // Flags may be X for memory/branch records, so only data processing may load CC
      if (bus.set_cc && is_data_proc) begin
        cc_d = bus.alu_flags;
      end
    end else if (transfer) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously; a held record is discarded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      cc_q        <= RESET_CC;
    end else begin
      out_valid_q <= out_valid_d;
      wb_en_q     <= wb_en_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      cc_q        <= cc_d;
    end
  end

  // Output drive straight from registers
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid_q;
    bus.wb_en     = wb_en_q;
    bus.wb_dest   = wb_dest_q;
    bus.wb_data   = wb_data_q;
    bus.mem_req   = mem_req_q;
    bus.mem_addr  = mem_addr_q;
    bus.br_taken  = br_taken_q;
    bus.br_target = br_target_q;
    bus.cc        = cc_q;
  end

endmodule

// File: tb/tb_stump_cc_writeback.sv
// Bench for stump_cc_writeback: directed cases plus random traffic, with expected records
// queued at accept time and compared by an independent output monitor.
module tb_stump_cc_writeback;

  localparam int unsigned DW       = 16;
  localparam logic [3:0]  RESET_CC = 4'b0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  stump_cc_writeback_if #(.DW(DW)) bus ();

  stump_cc_writeback #(
    .DW       (DW),
    .RESET_CC (RESET_CC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic          wb_en;
    logic [2:0]    wb_dest;
    logic [DW-1:0] wb_data;
    logic          mem_req;
    logic [DW-1:0] mem_addr;
    logic          br_taken;
    logic [DW-1:0] br_target;
    logic [3:0]    cc;
  } rec_t;

  rec_t       exp_q[$];
  bit         m_ov;
  logic [3:0] m_cc;
  rec_t       m_last;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Condition table: codes come in complementary pairs, odd code = inverse of even code
  function automatic bit cond_model(input int code, input logic [3:0] f);
    bit n, z, v, c, base;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (code / 2)
      0: base = 1'b1;
      1: base = !c && !z;
      2: base = !c;
      3: base = !z;
      4: base = !v;
      5: base = !n;
      6: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return (code % 2 == 1) ? !base : base;
  endfunction

  function automatic rec_t actual_rec();
    rec_t a;
    a.wb_en     = bus.wb_en;
    a.wb_dest   = bus.wb_dest;
    a.wb_data   = bus.wb_data;
    a.mem_req   = bus.mem_req;
    a.mem_addr  = bus.mem_addr;
    a.br_taken  = bus.br_taken;
    a.br_target = bus.br_target;
    a.cc        = bus.cc;
    return a;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ov   = 1'b0;
    m_cc   = RESET_CC;
    m_last = '0;
  endtask

  // One clock of stimulus; the model advances at the edge using the driven values
  task automatic drive(input bit v, input logic [2:0] f, input logic [DW-1:0] r,
                       input logic [3:0] fl, input bit s, input logic [2:0] d,
                       input logic [3:0] c, input bit ordy);
    bit acc;
    rec_t e;
    @(negedge clk);
    #1;
    bus.in_valid   = v;
    bus.alu_func   = f;
    bus.alu_result = r;
    bus.alu_flags  = fl;
    bus.set_cc     = s;
    bus.dest       = d;
    bus.cond       = c;
    bus.out_ready  = ordy;
    #0;
    chk("in_ready", 64'(bus.in_ready), 64'(!m_ov || ordy));
    @(posedge clk);
    if (rst_n) begin
      acc = v && (!m_ov || ordy);
      if (acc) begin
        e          = m_last;
        e.wb_en    = 1'b0;
        e.mem_req  = 1'b0;
        e.br_taken = 1'b0;
        if (f == 3'd6) begin
          e.mem_req  = 1'b1;
          e.mem_addr = r;
        end else if (f == 3'd7) begin
          e.br_taken  = cond_model(int'(c), m_cc);
          e.br_target = r;
        end else begin
          e.wb_en   = 1'b1;
          e.wb_dest = d;
          e.wb_data = r;
          if (s) m_cc = fl;
        end
        e.cc   = m_cc;
        m_last = e;
        exp_q.push_back(e);
        m_ov = 1'b1;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
    end
  endtask

  // Monitor: sampled after the drive point so out_ready is the value the next edge will use
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        if (bus.out_valid && exp_q.size() != 0) begin
          e = exp_q[0];
          chk("record", 64'(actual_rec()), 64'(e));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] r;
    bus.in_valid   = 1'b0;
    bus.alu_func   = '0;
    bus.alu_result = '0;
    bus.alu_flags  = '0;
    bus.set_cc     = 1'b0;
    bus.dest       = '0;
    bus.cond       = '0;
    bus.out_ready  = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_flags", 64'({bus.wb_en, bus.mem_req, bus.br_taken}), 64'(0));
    chk("rst_data", 64'({bus.wb_dest, bus.wb_data, bus.mem_addr, bus.br_target}), 64'(0));
    chk("rst_cc", 64'(bus.cc), 64'(RESET_CC));
    #3;
    rst_n = 1'b1;

    // ADD setting CC to 0101, then EQ (taken) and NE (not taken) branches
    drive(1, 3'd0, 16'h0000, 4'b0101, 1, 3'd3, 4'd0, 1);
    drive(1, 3'd7, 16'h0040, 4'b0000, 0, 3'd0, 4'd7, 1);
    drive(1, 3'd7, 16'h0040, 4'b0000, 0, 3'd0, 4'd6, 1);
    // Branch with S bit and unknown flags must leave CC alone; then a load/store address
    drive(1, 3'd7, 16'h0080, 4'bxxxx, 1, 3'd0, 4'd0, 1);
    drive(1, 3'd6, 16'h1234, 4'bxxxx, 1, 3'd5, 4'd0, 1);
    chk("cc_after_branch_x", 64'(bus.cc), 64'(4'b0101));

    // Stall: second record waits three cycles, then enters as the first drains
    drive(1, 3'd1, 16'hAAAA, 4'b1000, 1, 3'd1, 4'd0, 1);
    repeat (3) drive(1, 3'd2, 16'h5555, 4'b0011, 1, 3'd2, 4'd0, 0);
    drive(1, 3'd2, 16'h5555, 4'b0011, 1, 3'd2, 4'd0, 1);
    drive(0, 3'd0, 16'h0000, 4'b0000, 0, 3'd0, 4'd0, 1);

    // Every condition against every CC value
    for (int ccv = 0; ccv < 16; ccv++) begin
      for (int c = 0; c < 16; c++) begin
        r = 16'($urandom);
        drive(1, 3'd3, r, 4'(ccv), 1, 3'(c), 4'd0, 1);
        drive(1, 3'd7, r ^ 16'h00F0, 4'($urandom), 0, 3'd0, 4'(c), 1);
      end
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
            4'($urandom), 1'($urandom), 3'($urandom), 4'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    repeat (2) drive(0, 3'd0, 16'h0000, 4'b0000, 0, 3'd0, 4'd0, 1);

    // Asynchronous reset during a stall with CC = 1111
    drive(1, 3'd0, 16'hBEEF, 4'b1111, 1, 3'd7, 4'd0, 1);
    drive(1, 3'd4, 16'h0101, 4'b0001, 1, 3'd6, 4'd0, 0);
    #2;
    chk("pre_reset_cc", 64'(bus.cc), 64'(4'b1111));
    chk("pre_reset_valid", 64'(bus.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("async_rst_cc", 64'(bus.cc), 64'(RESET_CC));
    chk("async_rst_wb", 64'({bus.wb_en, bus.wb_dest, bus.wb_data}), 64'(0));
    model_reset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;

    // Nothing replayed after reset; traffic resumes from RESET_CC
    drive(0, 3'd0, 16'h0000, 4'b0000, 0, 3'd0, 4'd0, 1);
    drive(1, 3'd7, 16'h0200, 4'b0000, 0, 3'd0, 4'd4, 1);
    drive(1, 3'd5, 16'h0300, 4'b1010, 1, 3'd4, 4'd0, 1);
    repeat (3) drive(0, 3'd0, 16'h0000, 4'b0000, 0, 3'd0, 4'd0, 1);
    chk("drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
